// File: rtl/monitor_bus_master.sv
// rtl/monitor_bus_master.sv - slot control bus initiator with IRQ tracking
// Optional read polling is enabled by defining MONITOR_MASTER_POLL_EN.
module monitor_bus_master #(
    parameter logic [7:0] IDLE_BYTE  = 8'h30,
    parameter int         GAP_CYCLES = 2,
    parameter int         POLL_MAX   = 16
) (
    input  logic       clk_rw,
    input  logic       reset_x,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_cmd,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic       req_poll,
    input  logic [7:0] req_poll_mask,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [7:0] bus_data_out,
    output logic       bus_data_oe_x,
    input  logic [7:0] bus_data_in,
    input  logic       bus_resp_oe_x,
    output logic       bus_ax_d,
    output logic       bus_r_wx,
    input  logic       int_x,
    input  logic       int_oe_x,
    output logic       irq_pending,
    input  logic       irq_ack,
    output logic       busy
);

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_IRQ   = 2'd2;
    localparam logic [1:0] OP_RSV   = 2'd3;
    localparam logic [7:0] TOKEN_FF = 8'hFF;
    localparam logic [7:0] CMD_IRQ  = 8'h02;
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEL,
        S_CMD,
        S_ADDR,
        S_RDATA,
        S_WDATA,
        S_VAL,
        S_DESEL,
        S_GAP
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [1:0] op_q;
    logic [7:0] cmd_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic       err_pend;
    logic       sel_held;
    logic [3:0] gap_cnt;
    logic       accept;
    logic [1:0] eff_op;
    logic [7:0] eff_cmd;
    logic [7:0] cmd_byte;
    logic [7:0] rd_byte;
    logic       rd_err;
    logic       poll_again;
    logic       poll_err;

    logic [1:0] int_sync;
    logic [1:0] int_oe_sync;

    assign accept   = (state == S_IDLE) && req_valid;
    // CMD can be entered straight from IDLE when SEL is skipped, before the latch updates
    assign eff_op   = (state == S_IDLE) ? req_op  : op_q;
    assign eff_cmd  = (state == S_IDLE) ? req_cmd : cmd_q;
    assign cmd_byte = (eff_op == OP_IRQ) ? CMD_IRQ : eff_cmd;
    assign rd_byte  = bus_resp_oe_x ? 8'hFF : bus_data_in;
    assign rd_err   = bus_resp_oe_x;

`ifdef MONITOR_MASTER_POLL_EN
    logic       poll_q;
    logic [7:0] mask_q;
    logic [7:0] poll_cnt;
    logic [8:0] poll_reads;
    logic       poll_hit;

    assign poll_reads = {1'b0, poll_cnt} + 9'd1;
    assign poll_hit   = poll_q && ((rd_byte & mask_q) != 8'h00);
    assign poll_again = poll_hit && (poll_reads < 9'(POLL_MAX));
    assign poll_err   = poll_hit && !(poll_reads < 9'(POLL_MAX));

    always_ff @(posedge clk_rw or negedge reset_x) begin
        if (!reset_x) begin
            poll_q   <= 1'b0;
            mask_q   <= 8'h00;
            poll_cnt <= 8'h00;
        end else if (accept) begin
            poll_q   <= req_poll && (req_op == OP_READ);
            mask_q   <= req_poll_mask;
            poll_cnt <= 8'h00;
        end else if (state == S_RDATA) begin
            poll_cnt <= poll_cnt + 8'd1;
        end
    end
`else
    logic unused_poll;
    assign unused_poll = ^{req_poll, req_poll_mask};
    assign poll_again  = 1'b0;
    assign poll_err    = 1'b0;
`endif

    always_ff @(posedge clk_rw or negedge reset_x) begin
        if (!reset_x) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_op == OP_RSV) begin
                        state_next = S_GAP;
                    end else if (sel_held) begin
                        state_next = S_CMD;
                    end else begin
                        state_next = S_SEL;
                    end
                end
            end
            S_SEL:   state_next = S_CMD;
            S_CMD:   state_next = (op_q == OP_IRQ) ? S_VAL : S_ADDR;
            S_ADDR:  state_next = (op_q == OP_READ) ? S_RDATA : S_WDATA;
            S_RDATA: state_next = poll_again ? S_CMD : S_DESEL;
            S_WDATA: state_next = S_DESEL;
            S_VAL:   state_next = S_DESEL;
            S_DESEL: state_next = S_GAP;
            S_GAP:   state_next = (gap_cnt == GAP_LAST) ? S_IDLE : S_GAP;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_rw or negedge reset_x) begin
        if (!reset_x) begin
            op_q     <= OP_READ;
            cmd_q    <= 8'h00;
            addr_q   <= 8'h00;
            wdata_q  <= 8'h00;
            err_pend <= 1'b0;
        end else if (accept) begin
            op_q     <= req_op;
            cmd_q    <= req_cmd;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            err_pend <= (req_op == OP_RSV);
        end else if (state == S_RDATA) begin
            err_pend <= rd_err || poll_err;
        end
    end

    always_ff @(posedge clk_rw or negedge reset_x) begin
        if (!reset_x) begin
            sel_held <= 1'b0;
        end else if ((state == S_DESEL) && (op_q == OP_IRQ)) begin
            sel_held <= addr_q[0];
        end
    end

    always_ff @(posedge clk_rw or negedge reset_x) begin
        if (!reset_x) begin
            gap_cnt <= 4'd0;
        end else if (state == S_GAP) begin
            gap_cnt <= gap_cnt + 4'd1;
        end else begin
            gap_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk_rw or negedge reset_x) begin
        if (!reset_x) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= 8'hFF;
        end else begin
            req_ready <= (state_next == S_IDLE);
            busy      <= (state_next != S_IDLE);
            rsp_valid <= (state_next == S_GAP) && (state != S_GAP);
            if (state == S_RDATA) begin
                rsp_data <= rd_byte;
            end
            // A direct IDLE->GAP hop only happens for the reserved op
            if ((state_next == S_GAP) && (state != S_GAP)) begin
                rsp_err <= (state == S_IDLE) ? 1'b1 : err_pend;
            end
        end
    end

    always_ff @(posedge clk_rw or negedge reset_x) begin
        if (!reset_x) begin
            bus_data_out  <= IDLE_BYTE;
            bus_data_oe_x <= 1'b0;
            bus_ax_d      <= 1'b1;
            bus_r_wx      <= 1'b0;
        end else begin
            bus_data_out  <= IDLE_BYTE;
            bus_data_oe_x <= 1'b0;
            bus_ax_d      <= 1'b1;
            bus_r_wx      <= 1'b0;
            case (state_next)
                S_SEL, S_DESEL: bus_data_out <= TOKEN_FF;
                S_CMD:          bus_data_out <= cmd_byte;
                S_ADDR: begin
                    bus_data_out <= addr_q;
                    bus_ax_d     <= 1'b0;
                end
                S_RDATA: begin
                    bus_data_oe_x <= 1'b1;
                    bus_r_wx      <= 1'b1;
                end
                S_WDATA:        bus_data_out <= wdata_q;
                S_VAL:          bus_data_out <= {7'b0, addr_q[0]};
                default:        bus_data_out <= IDLE_BYTE;
            endcase
        end
    end

    always_ff @(posedge clk_rw or negedge reset_x) begin
        if (!reset_x) begin
            int_sync    <= 2'b11;
            int_oe_sync <= 2'b11;
            irq_pending <= 1'b0;
        end else begin
            int_sync    <= {int_sync[0], int_x};
            int_oe_sync <= {int_oe_sync[0], int_oe_x};
            if (!int_sync[1] && !int_oe_sync[1]) begin
                irq_pending <= 1'b1;
            end else if (irq_ack) begin
                irq_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_monitor_bus_master.sv
// tb/tb_monitor_bus_master.sv - directed self-checking bench for monitor_bus_master
module tb_monitor_bus_master;

    logic       clk_rw = 1'b0;
    logic       reset_x;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_cmd;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       req_poll;
    logic [7:0] req_poll_mask;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [7:0] bus_data_out;
    logic       bus_data_oe_x;
    logic [7:0] bus_data_in;
    logic       bus_resp_oe_x;
    logic       bus_ax_d;
    logic       bus_r_wx;
    logic       int_x;
    logic       int_oe_x;
    logic       irq_pending;
    logic       irq_ack;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] ph_data [0:79];
    logic       ph_axd  [0:79];
    logic       ph_rwx  [0:79];
    logic       ph_oe   [0:79];
    int         n_ph;
    int         n_rsp;
    int         n_rd;
    int         n_ff;
    logic [7:0] got_data;
    logic       got_err;
    logic [7:0] resp_first;
    int         resp_first_n;
    logic [7:0] resp_final;

    monitor_bus_master dut (
        .clk_rw        (clk_rw),
        .reset_x       (reset_x),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_cmd       (req_cmd),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_poll      (req_poll),
        .req_poll_mask (req_poll_mask),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .bus_data_out  (bus_data_out),
        .bus_data_oe_x (bus_data_oe_x),
        .bus_data_in   (bus_data_in),
        .bus_resp_oe_x (bus_resp_oe_x),
        .bus_ax_d      (bus_ax_d),
        .bus_r_wx      (bus_r_wx),
        .int_x         (int_x),
        .int_oe_x      (int_oe_x),
        .irq_pending   (irq_pending),
        .irq_ack       (irq_ack),
        .busy          (busy)
    );

    always #5 clk_rw = ~clk_rw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one request, then records every busy cycle until req_ready returns.
    task automatic run_req(input logic [1:0] op, input logic [7:0] cmd, input logic [7:0] addr,
                           input logic [7:0] wdata, input logic poll, input logic [7:0] mask);
        @(negedge clk_rw);
        req_op = op; req_cmd = cmd; req_addr = addr; req_wdata = wdata;
        req_poll = poll; req_poll_mask = mask; req_valid = 1'b1;
        @(posedge clk_rw);
        #1;
        req_valid = 1'b0;
        req_cmd = 8'hA5; req_addr = 8'h5A; req_wdata = 8'hC3; req_op = 2'd1;
        n_ph = 0; n_rsp = 0; n_rd = 0; n_ff = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk_rw);
            if (rsp_valid) begin
                n_rsp++;
                got_data = rsp_data;
                got_err  = rsp_err;
            end
            if (req_ready) break;
            ph_data[n_ph] = bus_data_out;
            ph_axd[n_ph]  = bus_ax_d;
            ph_rwx[n_ph]  = bus_r_wx;
            ph_oe[n_ph]   = bus_data_oe_x;
            n_ph++;
            if (!bus_data_oe_x && bus_data_out == 8'hFF) n_ff++;
            if (bus_data_oe_x) begin
                n_rd++;
                bus_data_in = (n_rd <= resp_first_n) ? resp_first : resp_final;
            end
        end
        vectors++;
        assert (req_ready === 1'b1) else begin
            miscompares++;
            $error("FAIL timeout observed=%0h expected=%0h", req_ready, 1'b1);
        end
    endtask

    initial begin
        reset_x = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_cmd = 8'h00; req_addr = 8'h00;
        req_wdata = 8'h00; req_poll = 1'b0; req_poll_mask = 8'h00; bus_data_in = 8'h00;
        bus_resp_oe_x = 1'b1; int_x = 1'b1; int_oe_x = 1'b1; irq_ack = 1'b0;
        resp_first = 8'h00; resp_first_n = 0; resp_final = 8'h00;
        repeat (3) @(posedge clk_rw);
        #1;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'hFF);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_bus_data", bus_data_out, 8'h30);
        chk("rst_oe", bus_data_oe_x, 1'b0);
        chk("rst_axd", bus_ax_d, 1'b1);
        chk("rst_rwx", bus_r_wx, 1'b0);
        chk("rst_irq", irq_pending, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk_rw);
        reset_x = 1'b1;

        // read id with responder
        bus_resp_oe_x = 1'b0; resp_final = 8'h88;
        run_req(2'd0, 8'h20, 8'h00, 8'h00, 1'b0, 8'h00);
        chk("rd_cycles", n_ph, 7);
        chk("rd_sel", ph_data[0], 8'hFF);
        chk("rd_cmd", ph_data[1], 8'h20);
        chk("rd_addr", ph_data[2], 8'h00);
        chk("rd_addr_axd", ph_axd[2], 1'b0);
        chk("rd_cmd_axd", ph_axd[1], 1'b1);
        chk("rd_rdata_oe", ph_oe[3], 1'b1);
        chk("rd_rdata_rwx", ph_rwx[3], 1'b1);
        chk("rd_desel", ph_data[4], 8'hFF);
        chk("rd_desel_oe", ph_oe[4], 1'b0);
        chk("rd_gap", ph_data[5], 8'h30);
        chk("rd_nrsp", n_rsp, 1);
        chk("rd_data", got_data, 8'h88);
        chk("rd_err", got_err, 1'b0);
        chk("rd_hold", rsp_data, 8'h88);

        // read with no responder
        bus_resp_oe_x = 1'b1; resp_final = 8'h55;
        run_req(2'd0, 8'h20, 8'h00, 8'h00, 1'b0, 8'h00);
        chk("nr_data", got_data, 8'hFF);
        chk("nr_err", got_err, 1'b1);

        // write
        bus_resp_oe_x = 1'b0;
        run_req(2'd1, 8'h22, 8'h27, 8'h09, 1'b0, 8'h00);
        chk("wr_cycles", n_ph, 7);
        chk("wr_sel", ph_data[0], 8'hFF);
        chk("wr_cmd", ph_data[1], 8'h22);
        chk("wr_addr", ph_data[2], 8'h27);
        chk("wr_addr_axd", ph_axd[2], 1'b0);
        chk("wr_data", ph_data[3], 8'h09);
        chk("wr_data_rwx", ph_rwx[3], 1'b0);
        chk("wr_data_oe", ph_oe[3], 1'b0);
        chk("wr_desel", ph_data[4], 8'hFF);
        chk("wr_err", got_err, 1'b0);
        chk("wr_nrsp", n_rsp, 1);

        // irq config enable, req_cmd ignored
        run_req(2'd2, 8'h77, 8'h01, 8'h00, 1'b0, 8'h00);
        chk("ie_cycles", n_ph, 6);
        chk("ie_sel", ph_data[0], 8'hFF);
        chk("ie_cmd", ph_data[1], 8'h02);
        chk("ie_val", ph_data[2], 8'h01);
        chk("ie_val_axd", ph_axd[2], 1'b1);
        chk("ie_desel", ph_data[3], 8'hFF);

        // read with target held selected
        resp_final = 8'h3C;
        run_req(2'd0, 8'h23, 8'h00, 8'h00, 1'b0, 8'h00);
        chk("sh_cycles", n_ph, 6);
        chk("sh_first", ph_data[0], 8'h23);
        chk("sh_data", got_data, 8'h3C);

        // irq config disable, still skips SEL
        run_req(2'd2, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
        chk("id_cycles", n_ph, 5);
        chk("id_first", ph_data[0], 8'h02);
        chk("id_val", ph_data[1], 8'h00);

        run_req(2'd0, 8'h23, 8'h00, 8'h00, 1'b0, 8'h00);
        chk("cl_first", ph_data[0], 8'hFF);
        chk("cl_cycles", n_ph, 7);

        // reserved op
        run_req(2'd3, 8'h20, 8'h00, 8'h00, 1'b0, 8'h00);
        chk("rs_cycles", n_ph, 2);
        chk("rs_bus", ph_data[0], 8'h30);
        chk("rs_nrsp", n_rsp, 1);
        chk("rs_err", got_err, 1'b1);

        // poll request is a single read in this build unless the feature is on
        resp_first = 8'h09; resp_first_n = 3; resp_final = 8'h00;
        run_req(2'd0, 8'h22, 8'h27, 8'h00, 1'b1, 8'hFF);
`ifdef MONITOR_MASTER_POLL_EN
        chk("pl_reads", n_rd, 4);
        chk("pl_ff", n_ff, 2);
        chk("pl_cycles", n_ph, 16);
        chk("pl_data", got_data, 8'h00);
        chk("pl_err", got_err, 1'b0);
        resp_first_n = 1000;
        run_req(2'd0, 8'h22, 8'h27, 8'h00, 1'b1, 8'hFF);
        chk("ps_reads", n_rd, 16);
        chk("ps_data", got_data, 8'h09);
        chk("ps_err", got_err, 1'b1);
`else
        chk("np_reads", n_rd, 1);
        chk("np_ff", n_ff, 2);
        chk("np_data", got_data, 8'h09);
        chk("np_err", got_err, 1'b0);
`endif
        resp_first_n = 0;

        // interrupt
        @(negedge clk_rw);
        int_oe_x = 1'b0; int_x = 1'b0;
        repeat (3) @(posedge clk_rw);
        #1;
        chk("irq_set", irq_pending, 1'b1);
        irq_ack = 1'b1;
        repeat (2) @(posedge clk_rw);
        #1;
        chk("irq_ack_held", irq_pending, 1'b1);
        irq_ack = 1'b0;
        int_oe_x = 1'b1; int_x = 1'b1;
        repeat (3) @(posedge clk_rw);
        #1;
        chk("irq_sticky", irq_pending, 1'b1);
        irq_ack = 1'b1;
        @(posedge clk_rw);
        #1;
        irq_ack = 1'b0;
        chk("irq_clear", irq_pending, 1'b0);

        // async reset mid-sequence
        @(negedge clk_rw);
        req_op = 2'd1; req_cmd = 8'h22; req_addr = 8'h27; req_wdata = 8'h09; req_valid = 1'b1;
        @(posedge clk_rw);
        #1;
        req_valid = 1'b0;
        @(posedge clk_rw);
        #1;
        chk("mid_busy", busy, 1'b1);
        chk("mid_cmd", bus_data_out, 8'h22);
        #2;
        reset_x = 1'b0;
        #1;
        chk("ar_bus", bus_data_out, 8'h30);
        chk("ar_busy", busy, 1'b0);
        chk("ar_ready", req_ready, 1'b1);
        @(negedge clk_rw);
        reset_x = 1'b1;
        @(negedge clk_rw);
        chk("ar_idle_bus", bus_data_out, 8'h30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
